// File: rtl/masked_bv8_inv_lanes_pkg.sv
// Shared byte type, inverter latency, randomness sizing and GF(2^8) helpers
// for the masked inverter lanes (AES polynomial x^8+x^4+x^3+x+1).
package aes128_package;

    typedef logic [7:0] bv8_t;

    localparam int INV_LATENCY = 3;
    localparam int INV_MULTS   = 6;

    function automatic int num_inv_random(input int shares);
        return INV_MULTS * 8 * ((shares * (shares - 1)) / 2);
    endfunction

    function automatic int lanes_inv_random(input int lanes, input int shares);
        return lanes * num_inv_random(shares);
    endfunction

    function automatic bv8_t gf_mul(input bv8_t a, input bv8_t b);
        bv8_t acc;
        bv8_t sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            else      acc = acc;
            if (sh[7]) sh = {sh[6:0], 1'b0} ^ 8'h1B;
            else       sh = {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Squaring is linear in GF(2^8), so it can be applied to each share on its own.
    function automatic bv8_t gf_sq_n(input bv8_t a, input int n);
        bv8_t r;
        r = a;
        for (int i = 0; i < n; i++) r = gf_mul(r, r);
        return r;
    endfunction

endpackage

// File: rtl/masked_bv8_inv_lanes_inv.sv
// masked_bv8_inv: three-stage masked GF(2^8) inverter computing x^254 as
// ((x^6 * x^24) * (x^96 * x^128)) with share-wise squarings and DOM-style products.
module masked_bv8_inv
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2
) (
    input  logic                                  in_clock,
    input  logic                                  in_reset,
    input  bv8_t [NUM_SHARES-1:0]                 in_a,
    input  logic [num_inv_random(NUM_SHARES)-1:0] in_random,
    output bv8_t [NUM_SHARES-1:0]                 out_b
);

    localparam int PAIRS = (NUM_SHARES * (NUM_SHARES - 1)) / 2;
    localparam int ZW    = PAIRS * 8;

    typedef bv8_t [NUM_SHARES-1:0] shares_t;

    localparam shares_t ZERO_SH = {NUM_SHARES{8'h00}};

    function automatic shares_t pow2n(input shares_t a, input int n);
        shares_t r;
        for (int s = 0; s < NUM_SHARES; s++) r[s] = gf_sq_n(a[s], n);
        return r;
    endfunction

    // Each fresh byte z_ij is added to both cross terms so it cancels in the sum.
    function automatic shares_t dom_mul(input shares_t a, input shares_t b, input logic [ZW-1:0] z);
        shares_t q;
        int p;
        p = 0;
        for (int i = 0; i < NUM_SHARES; i++) q[i] = gf_mul(a[i], b[i]);
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = i + 1; j < NUM_SHARES; j++) begin
                q[i] = q[i] ^ gf_mul(a[i], b[j]) ^ z[p*8 +: 8];
                q[j] = q[j] ^ gf_mul(a[j], b[i]) ^ z[p*8 +: 8];
                p = p + 1;
            end
        end
        return q;
    endfunction

    shares_t r_p, r_q, r_r, r_x128, r_s, r_t, r_out;

    // Pipeline: stage 1 x^6/x^24/x^96/x^128, stage 2 x^30/x^224, stage 3 x^254.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_p    <= ZERO_SH;
            r_q    <= ZERO_SH;
            r_r    <= ZERO_SH;
            r_x128 <= ZERO_SH;
            r_s    <= ZERO_SH;
            r_t    <= ZERO_SH;
            r_out  <= ZERO_SH;
        end else begin
            r_p    <= dom_mul(pow2n(in_a, 1), pow2n(in_a, 2), in_random[0*ZW +: ZW]);
            r_q    <= dom_mul(pow2n(in_a, 3), pow2n(in_a, 4), in_random[1*ZW +: ZW]);
            r_r    <= dom_mul(pow2n(in_a, 5), pow2n(in_a, 6), in_random[2*ZW +: ZW]);
            r_x128 <= pow2n(in_a, 7);
            r_s    <= dom_mul(r_p, r_q, in_random[3*ZW +: ZW]);
            r_t    <= dom_mul(r_r, r_x128, in_random[4*ZW +: ZW]);
            r_out  <= dom_mul(r_s, r_t, in_random[5*ZW +: ZW]);
        end
    end

    assign out_b = r_out;

endmodule

// File: rtl/masked_bv8_inv_lanes.sv
// Parallel masked GF(2^8) inverter lanes with valid/tag/lane-enable delay lines and
// in-flight tracking; MASKED_INV_RAND_CHECK_EN adds a sticky randomness-starvation flag.
module masked_bv8_inv_lanes
    import aes128_package::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int NUM_LANES  = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                                               in_clock,
    input  logic                                               in_reset,
    input  logic                                               in_valid,
    input  logic [NUM_LANES-1:0]                               in_lane_en,
    input  bv8_t [NUM_LANES-1:0][NUM_SHARES-1:0]               in_a,
    input  logic [TAG_WIDTH-1:0]                               in_tag,
    input  logic [lanes_inv_random(NUM_LANES, NUM_SHARES)-1:0] in_random,
    input  logic                                               in_rand_valid,
    input  logic                                               in_clear_err,
    output logic                                               out_valid,
    output logic [NUM_LANES-1:0]                               out_lane_en,
    output bv8_t [NUM_LANES-1:0][NUM_SHARES-1:0]               out_b,
    output logic [TAG_WIDTH-1:0]                               out_tag,
    output logic                                               out_busy,
    output logic                                               out_rand_err
);

    localparam int LANE_RW = num_inv_random(NUM_SHARES);
    localparam bv8_t [NUM_SHARES-1:0] ZERO_SH = {NUM_SHARES{8'h00}};

    logic [INV_LATENCY-1:0]                r_valid;
    logic [INV_LATENCY-1:0][NUM_LANES-1:0] r_lane_en;
    logic [INV_LATENCY-1:0][TAG_WIDTH-1:0] r_tag;
    logic [1:0]                            r_count;
    logic                                  r_busy;
    logic [1:0]                            w_count_next;
    logic                                  w_accept;
    logic                                  w_retire;
    bv8_t [NUM_SHARES-1:0]                 w_inv_in  [NUM_LANES];
    bv8_t [NUM_SHARES-1:0]                 w_inv_out [NUM_LANES];

    assign w_accept = in_valid;
    assign w_retire = r_valid[INV_LATENCY-1];

    // Idle or disabled lanes feed an all-zero sharing into their inverter.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            w_inv_in[k] = ZERO_SH;
            if (in_valid && in_lane_en[k]) w_inv_in[k] = in_a[k];
            else                           w_inv_in[k] = ZERO_SH;
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        masked_bv8_inv #(
            .NUM_SHARES (NUM_SHARES)
        ) u_inv (
            .in_clock  (in_clock),
            .in_reset  (in_reset),
            .in_a      (w_inv_in[k]),
            .in_random (in_random[k*LANE_RW +: LANE_RW]),
            .out_b     (w_inv_out[k])
        );
    end

    // In-flight count: accept and retire in the same cycle cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_accept && !w_retire)      w_count_next = r_count + 2'd1;
        else if (!w_accept && w_retire) w_count_next = r_count - 2'd1;
        else                            w_count_next = r_count;
    end

    // Sideband delay lines; tag and lane enables are only captured with a valid beat.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_valid   <= {INV_LATENCY{1'b0}};
            r_lane_en <= {(INV_LATENCY*NUM_LANES){1'b0}};
            r_tag     <= {(INV_LATENCY*TAG_WIDTH){1'b0}};
            r_count   <= 2'd0;
            r_busy    <= 1'b0;
        end else begin
            r_valid   <= {r_valid[INV_LATENCY-2:0], in_valid};
            r_lane_en <= {r_lane_en[INV_LATENCY-2:0], in_lane_en & {NUM_LANES{in_valid}}};
            r_tag     <= {r_tag[INV_LATENCY-2:0], in_valid ? in_tag : {TAG_WIDTH{1'b0}}};
            r_count   <= w_count_next;
            r_busy    <= (w_count_next != 2'd0);
        end
    end

    always_comb begin
        out_b = {NUM_LANES{ZERO_SH}};
        for (int k = 0; k < NUM_LANES; k++) begin
            if (r_lane_en[INV_LATENCY-1][k]) out_b[k] = w_inv_out[k];
            else                             out_b[k] = ZERO_SH;
        end
    end

    assign out_valid   = r_valid[INV_LATENCY-1];
    assign out_lane_en = r_lane_en[INV_LATENCY-1];
    assign out_tag     = r_tag[INV_LATENCY-1];
    assign out_busy    = r_busy;

`ifdef MASKED_INV_RAND_CHECK_EN
    logic r_rand_err;
    logic w_starved;

    assign w_starved = !in_rand_valid && (in_valid || (r_count != 2'd0));

    // Sticky flag; a violation in the same cycle as a clear keeps it set.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset)         r_rand_err <= 1'b0;
        else if (w_starved)    r_rand_err <= 1'b1;
        else if (in_clear_err) r_rand_err <= 1'b0;
        else                   r_rand_err <= r_rand_err;
    end

    assign out_rand_err = r_rand_err;
`else
    logic w_unused_rand;

    assign w_unused_rand = in_rand_valid ^ in_clear_err;
    assign out_rand_err  = 1'b0;
`endif

endmodule

// File: tb/tb_masked_bv8_inv_lanes.sv
// Randomized bench for masked_bv8_inv_lanes against a beat-level reference model
// (unmasked values, brute-force inverse table, 3-cycle delivery, reset discard).
module tb_masked_bv8_inv_lanes;

    localparam int NL = 4;
    localparam int NS = 2;
    localparam int RW = 192;
    localparam int HMAX = 4096;

`ifdef MASKED_INV_RAND_CHECK_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      in_reset;
    logic                      in_valid;
    logic [NL-1:0]             in_lane_en;
    logic [NL-1:0][NS-1:0][7:0] in_a;
    logic [3:0]                in_tag;
    logic [RW-1:0]             in_random;
    logic                      in_rand_valid;
    logic                      in_clear_err;
    logic                      out_valid;
    logic [NL-1:0]             out_lane_en;
    logic [NL-1:0][NS-1:0][7:0] out_b;
    logic [3:0]                out_tag;
    logic                      out_busy;
    logic                      out_rand_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic       exp_valid [0:HMAX-1];
    logic [3:0] exp_tag   [0:HMAX-1];
    logic [3:0] exp_en    [0:HMAX-1];
    logic [7:0] exp_x     [0:HMAX-1][0:NL-1];
    logic       err_model = 1'b0;
    logic [7:0] inv_tab   [0:255];

    masked_bv8_inv_lanes dut (
        .in_clock      (clk),
        .in_reset      (in_reset),
        .in_valid      (in_valid),
        .in_lane_en    (in_lane_en),
        .in_a          (in_a),
        .in_tag        (in_tag),
        .in_random     (in_random),
        .in_rand_valid (in_rand_valid),
        .in_clear_err  (in_clear_err),
        .out_valid     (out_valid),
        .out_lane_en   (out_lane_en),
        .out_b         (out_b),
        .out_tag       (out_tag),
        .out_busy      (out_busy),
        .out_rand_err  (out_rand_err)
    );

    always #5 clk = ~clk;

    // Carry-less product followed by polynomial long division by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic model_busy(input int c);
        logic b;
        b = 1'b0;
        for (int d = 1; d <= 3; d++)
            if (c - d >= 0 && exp_valid[c - d]) b = 1'b1;
        return b;
    endfunction

    // Record each cycle's inputs as seen by the clock edge that samples them.
    always @(posedge clk) begin
        logic busy_now;
        busy_now = model_busy(cyc);
        if (!in_reset) begin
            for (int d = 0; d <= 2; d++)
                if (cyc - d >= 0) exp_valid[cyc - d] = 1'b0;
            err_model = 1'b0;
        end else begin
            exp_valid[cyc] = in_valid;
            exp_tag[cyc]   = in_tag;
            exp_en[cyc]    = in_lane_en;
            for (int l = 0; l < NL; l++) exp_x[cyc][l] = in_a[l][0] ^ in_a[l][1];
            err_model = ERR_ON && ((!in_rand_valid && (in_valid || busy_now)) ||
                                   (err_model && !in_clear_err));
        end
        cyc++;
    end

    // Compare all outputs every cycle against the model.
    always @(negedge clk) begin
        int c;
        logic ev;
        logic [7:0] x;
        logic [7:0] u;
        if (!in_reset) begin
            chk("rst_valid", out_valid, 1'b0);
            chk("rst_busy", out_busy, 1'b0);
            chk("rst_err", out_rand_err, 1'b0);
            chk("rst_outb", out_b, 64'h0);
            chk("rst_tag", out_tag, 4'h0);
            chk("rst_lane_en", out_lane_en, 4'h0);
        end else begin
            c  = cyc - 3;
            ev = (c >= 0) ? exp_valid[c] : 1'b0;
            chk("valid", out_valid, ev);
            if (ev) begin
                chk("tag", out_tag, exp_tag[c]);
                chk("lane_en", out_lane_en, exp_en[c]);
            end
            for (int l = 0; l < NL; l++) begin
                u = out_b[l][0] ^ out_b[l][1];
                if (ev && exp_en[c][l]) begin
                    x = exp_x[c][l];
                    chk("lane_inv", u, inv_tab[x]);
                    if (x != 8'h00) chk("lane_prod", gmul(x, u), 8'h01);
                end else begin
                    chk("lane_off", out_b[l], 16'h0000);
                end
            end
            chk("busy", out_busy, model_busy(cyc));
            chk("rand_err", out_rand_err, err_model);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < RW / 32; i++) in_random[i*32 +: 32] = $urandom;
    endtask

    task automatic drive(input logic v, input logic [3:0] en, input logic [3:0] tag,
                         input logic [NL-1:0][7:0] xs);
        logic [7:0] m;
        in_valid   = v;
        in_lane_en = en;
        in_tag     = tag;
        for (int l = 0; l < NL; l++) begin
            m          = 8'($urandom);
            in_a[l][1] = m;
            in_a[l][0] = xs[l] ^ m;
        end
    endtask

    task automatic idle();
        drive(1'b0, 4'($urandom), 4'($urandom), $urandom);
    endtask

    initial begin
        int pulses;
        logic [31:0] rnd;

        for (int i = 0; i < HMAX; i++) exp_valid[i] = 1'b0;
        for (int x = 0; x < 256; x++) begin
            inv_tab[x] = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_tab[x] = 8'(y);
        end
        chk("model_inv00", inv_tab[0], 8'h00);
        chk("model_inv01", inv_tab[1], 8'h01);
        chk("model_inv02", inv_tab[2], 8'h8D);
        chk("model_inv53", inv_tab[8'h53], 8'hCA);

        in_reset      = 1'b0;
        in_rand_valid = 1'b1;
        in_clear_err  = 1'b0;
        in_random     = {RW{1'b0}};
        idle();
        repeat (3) step();
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_busy", out_busy, 1'b0);
        chk("reset_err", out_rand_err, 1'b0);
        in_reset = 1'b1;
        repeat (2) step();

        // Single beat: lane 0 carries shares {5A,5A}, i.e. value 00.
        drive(1'b1, 4'hF, 4'h3, 32'h11223300);
        in_a[0][0] = 8'h5A;
        in_a[0][1] = 8'h5A;
        step();
        idle();
        step();
        step();
        chk("single_valid", out_valid, 1'b1);
        chk("single_tag", out_tag, 4'h3);
        chk("single_lane0", out_b[0][0] ^ out_b[0][1], 8'h00);
        repeat (3) step();

        // Six accepts then idle: busy spans cycles 1..8.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'hF, 4'(i), $urandom);
            step();
            if (i == 0) chk("busy_c1", out_busy, 1'b1);
        end
        idle();
        step();
        step();
        chk("busy_c8", out_busy, 1'b1);
        step();
        chk("busy_c9", out_busy, 1'b0);

        // Lane mask 0101.
        drive(1'b1, 4'b0101, 4'hA, $urandom);
        step();
        idle();
        step();
        step();
        chk("mask_lane_en", out_lane_en, 4'b0101);
        chk("mask_off13", {out_b[3], out_b[1]}, 32'h0);
        repeat (3) step();

        // 256 back-to-back beats sweeping lane 0 through every byte value.
        pulses = 0;
        for (int x = 0; x < 256; x++) begin
            rnd = $urandom;
            drive(1'b1, 4'hF, 4'(x), {rnd[31:8], 8'(x)});
            step();
            if (out_valid) pulses++;
        end
        idle();
        repeat (3) begin
            step();
            if (out_valid) pulses++;
        end
        chk("sweep_pulses", pulses, 256);

        // Reset mid-flight: beats at cycles 0 and 1, reset at cycle 2.
        drive(1'b1, 4'hF, 4'h5, $urandom);
        step();
        drive(1'b1, 4'hF, 4'h6, $urandom);
        step();
        in_reset = 1'b0;
        idle();
        step();
        step();
        in_reset = 1'b1;
        pulses = 0;
        repeat (5) begin
            step();
            if (out_valid) pulses++;
        end
        chk("rst_flight_pulses", pulses, 0);
        chk("rst_flight_busy", out_busy, 1'b0);

        // Randomness starvation one cycle after an accept.
        in_clear_err = 1'b1;
        repeat (4) step();
        in_clear_err = 1'b0;
        drive(1'b1, 4'hF, 4'h7, $urandom);
        step();
        idle();
        in_rand_valid = 1'b0;
        step();
        in_rand_valid = 1'b1;
        chk("starve_set", out_rand_err, ERR_ON);
        repeat (2) step();
        chk("starve_sticky", out_rand_err, ERR_ON);
        in_clear_err = 1'b1;
        step();
        in_clear_err = 1'b0;
        chk("starve_clear", out_rand_err, 1'b0);
        drive(1'b1, 4'hF, 4'h8, $urandom);
        in_rand_valid = 1'b0;
        in_clear_err  = 1'b1;
        step();
        in_rand_valid = 1'b1;
        in_clear_err  = 1'b0;
        idle();
        chk("starve_clear_collide", out_rand_err, ERR_ON);
        repeat (4) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), $urandom);
            in_rand_valid = ($urandom_range(0, 15) != 0);
            in_clear_err  = ($urandom_range(0, 7) == 0);
            step();
        end
        idle();
        in_rand_valid = 1'b1;
        in_clear_err  = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
